// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: owns the program counter and the {V,N,Z} status register and
// resolves conditional, indirect and link branches over a three-state request/done handshake.
module branch_resolve_unit #(
  parameter int PC_W  = 9,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       status_in,
  input  logic             load_status,
  input  logic             br_req,
  input  logic [2:0]       br_cond,
  input  logic             br_indirect,
  input  logic             br_link,
  input  logic [IMM_W-1:0] imm,
  input  logic [15:0]      rd_val,
  input  logic             pc_inc,
  input  logic             pc_load,
  input  logic [PC_W-1:0]  pc_init,
  output logic [PC_W-1:0]  pc,
  output logic [2:0]       status,
  output logic             br_busy,
  output logic             br_done,
  output logic             br_taken,
  output logic             link_we,
  output logic [PC_W-1:0]  link_val
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [2:0]        status_q;
  logic              busy_q;
  logic              done_q;
  logic              taken_q;
  logic              link_we_q;
  logic [PC_W-1:0]   link_val_q;

  // Request snapshot taken on the accept edge; later inputs cannot disturb the branch.
  logic [2:0]        cond_q;
  logic              ind_q;
  logic              link_q;
  logic [IMM_W-1:0]  imm_q;
  logic [PC_W-1:0]   rdv_q;
  logic [PC_W-1:0]   spc_q;
  logic [2:0]        sst_q;

  // Outcome registered in EVAL and applied in COMMIT.
  logic              taken_d;
  logic [PC_W-1:0]   target_d;
  logic              eval_taken_q;
  logic [PC_W-1:0]   eval_target_q;

  logic [PC_W-1:0]   seq_pc_s;
  logic [PC_W-1:0]   imm_ext_s;
  logic              n_ne_v_s;
  logic              rd_val_unused_s;

  assign seq_pc_s        = spc_q + PC_W'(1'b1);
  assign imm_ext_s       = {{(PC_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
  assign n_ne_v_s        = sst_q[1] ^ sst_q[2];
  assign rd_val_unused_s = ^rd_val[15:PC_W];

  // Condition decode and target selection from the snapshot.
  always_comb begin
    taken_d = 1'b0;
    case (cond_q)
      3'b000:  taken_d = 1'b1;
      3'b001:  taken_d = sst_q[0];
      3'b010:  taken_d = ~sst_q[0];
      3'b011:  taken_d = n_ne_v_s;
      3'b100:  taken_d = n_ne_v_s | sst_q[0];
      default: taken_d = 1'b0;
    endcase
    if (ind_q) begin
      target_d = rdv_q;
    end else begin
      target_d = seq_pc_s + imm_ext_s;
    end
  end

  // Status register, PC and branch FSM; pc_load pre-empts any branch in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      status_q      <= 3'b000;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      taken_q       <= 1'b0;
      link_we_q     <= 1'b0;
      link_val_q    <= '0;
      cond_q        <= 3'b000;
      ind_q         <= 1'b0;
      link_q        <= 1'b0;
      imm_q         <= '0;
      rdv_q         <= '0;
      spc_q         <= '0;
      sst_q         <= 3'b000;
      eval_taken_q  <= 1'b0;
      eval_target_q <= '0;
    end else begin
      if (load_status) begin
        status_q <= status_in;
      end
      done_q    <= 1'b0;
      link_we_q <= 1'b0;
      if (pc_load) begin
        pc_q    <= pc_init;
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (br_req) begin
              cond_q  <= br_cond;
              ind_q   <= br_indirect;
              link_q  <= br_link;
              imm_q   <= imm;
              rdv_q   <= rd_val[PC_W-1:0];
              spc_q   <= pc_q;
              sst_q   <= status_q;
              state_q <= S_EVAL;
              busy_q  <= 1'b1;
            end else if (pc_inc) begin
              pc_q <= pc_q + PC_W'(1'b1);
            end
          end
          S_EVAL: begin
            eval_taken_q  <= taken_d;
            eval_target_q <= target_d;
            state_q       <= S_COMMIT;
          end
          S_COMMIT: begin
            pc_q    <= eval_taken_q ? eval_target_q : seq_pc_s;
            done_q  <= 1'b1;
            taken_q <= eval_taken_q;
            if (link_q && eval_taken_q) begin
              link_we_q  <= 1'b1;
              link_val_q <= seq_pc_s;
            end
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pc       = pc_q;
  assign status   = status_q;
  assign br_busy  = busy_q;
  assign br_done  = done_q;
  assign br_taken = taken_q;
  assign link_we  = link_we_q;
  assign link_val = link_val_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected branch outcomes are queued when a
// request is driven and checked when br_done fires.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  status_in = 3'b000;
  logic        load_status = 1'b0;
  logic        br_req = 1'b0;
  logic [2:0]  br_cond = 3'b000;
  logic        br_indirect = 1'b0;
  logic        br_link = 1'b0;
  logic [7:0]  imm = 8'h00;
  logic [15:0] rd_val = 16'h0000;
  logic        pc_inc = 1'b0;
  logic        pc_load = 1'b0;
  logic [8:0]  pc_init = 9'h000;
  logic [8:0]  pc;
  logic [2:0]  status;
  logic        br_busy, br_done, br_taken, link_we;
  logic [8:0]  link_val;

  typedef struct {
    logic [8:0] pc;
    logic       taken;
    logic       lwe;
    logic [8:0] lval;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] model_link = 9'h000;

  branch_resolve_unit #(.PC_W(9), .IMM_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .status_in(status_in), .load_status(load_status),
    .br_req(br_req), .br_cond(br_cond), .br_indirect(br_indirect), .br_link(br_link),
    .imm(imm), .rd_val(rd_val), .pc_inc(pc_inc), .pc_load(pc_load), .pc_init(pc_init),
    .pc(pc), .status(status), .br_busy(br_busy), .br_done(br_done), .br_taken(br_taken),
    .link_we(link_we), .link_val(link_val)
  );

  always #5 clk = ~clk;

  task automatic set_pc(input logic [8:0] v);
    @(negedge clk); pc_load = 1'b1; pc_init = v;
    @(posedge clk); @(negedge clk); pc_load = 1'b0;
    vectors++; if (pc !== v) begin miscompares++; $display("FAIL set_pc: pc=%h expected %h", pc, v); end
  endtask

  task automatic load_st(input logic [2:0] v);
    @(negedge clk); load_status = 1'b1; status_in = v;
    @(posedge clk); @(negedge clk); load_status = 1'b0;
    vectors++; if (status !== v) begin miscompares++; $display("FAIL load_status: status=%b expected %b", status, v); end
  endtask

  // Issue one branch (pc_inc also asserted to prove br_req wins), optionally with a
  // same-cycle status load and a second request poked in while busy.
  task automatic do_branch(input logic [2:0] cond, input logic ind, input logic lnk,
                           input logic [7:0] im, input logic [15:0] rd, input logic [8:0] spc,
                           input logic [8:0] epc, input logic etk, input logic ls,
                           input logic [2:0] ls_val, input logic poke);
    exp_t e;
    int   lat;
    bit   got;
    e.pc = epc; e.taken = etk; e.lwe = lnk & etk;
    e.lval = (lnk && etk) ? spc + 9'd1 : model_link;
    model_link = e.lval;
    @(negedge clk);
    br_req = 1'b1; br_cond = cond; br_indirect = ind; br_link = lnk; imm = im; rd_val = rd;
    pc_inc = 1'b1; load_status = ls; status_in = ls_val;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    br_req = poke; pc_inc = poke; load_status = 1'b0;
    if (poke) begin br_cond = 3'b000; br_indirect = 1'b0; br_link = 1'b1; end
    vectors++; if (br_busy !== 1'b1) begin miscompares++; $display("FAIL busy_eval: br_busy=%b expected 1", br_busy); end
    vectors++; if (pc !== spc) begin miscompares++; $display("FAIL pc_during_eval: pc=%h expected %h", pc, spc); end
    got = 1'b0; lat = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk); br_req = 1'b0; pc_inc = 1'b0;
      if (br_done === 1'b1) begin got = 1'b1; lat = n; break; end
    end
    e = sb.pop_front();
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL done_timeout: br_done never seen, expected within 2 cycles");
    end else begin
      if (lat != 2) begin miscompares++; $display("FAIL latency: %0d cycles expected 2", lat); end
      vectors++; if (pc !== e.pc) begin miscompares++; $display("FAIL branch_pc: pc=%h expected %h", pc, e.pc); end
      vectors++; if (br_taken !== e.taken) begin miscompares++; $display("FAIL br_taken: %b expected %b", br_taken, e.taken); end
      vectors++; if (link_we !== e.lwe) begin miscompares++; $display("FAIL link_we: %b expected %b", link_we, e.lwe); end
      vectors++; if (link_val !== e.lval) begin miscompares++; $display("FAIL link_val: %h expected %h", link_val, e.lval); end
      vectors++; if (br_busy !== 1'b0) begin miscompares++; $display("FAIL busy_done: br_busy=%b expected 0", br_busy); end
      @(negedge clk);
      vectors++; if ({br_done, link_we} !== 2'b00) begin miscompares++; $display("FAIL pulse_width: done,lwe=%b expected 00", {br_done, link_we}); end
    end
    if (poke) begin
      for (int n = 0; n < 3; n++) begin
        @(negedge clk);
        vectors++; if (br_done !== 1'b0) begin miscompares++; $display("FAIL ignored_req: br_done=%b expected 0", br_done); end
      end
      vectors++; if (pc !== epc) begin miscompares++; $display("FAIL ignored_pc: pc=%h expected %h", pc, epc); end
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++; if ({pc, status} !== 12'h000) begin miscompares++; $display("FAIL reset_pc_status: pc=%h status=%b expected 000/000", pc, status); end
    vectors++; if ({br_busy, br_done, br_taken, link_we} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: %b expected 0000", {br_busy, br_done, br_taken, link_we}); end
    vectors++; if (link_val !== 9'h000) begin miscompares++; $display("FAIL reset_link_val: %h expected 000", link_val); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_eval;
    set_pc(9'h020);
    load_st(3'b111);
    @(negedge clk); br_req = 1'b1; br_cond = 3'b000; br_indirect = 1'b0; br_link = 1'b1; imm = 8'h10;
    @(posedge clk); @(negedge clk); br_req = 1'b0;
    reset_n = 1'b0; #1;
    vectors++; if ({pc, status, br_busy} !== 13'h0000) begin miscompares++; $display("FAIL reset_mid_eval: pc=%h status=%b busy=%b expected 000/000/0", pc, status, br_busy); end
    @(negedge clk); reset_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      vectors++; if ({br_done, link_we, br_busy} !== 3'b000) begin miscompares++; $display("FAIL no_done_after_reset: done,lwe,busy=%b expected 000", {br_done, link_we, br_busy}); end
    end
    do_branch(3'b010, 1'b0, 1'b0, 8'h03, 16'h0000, 9'h000, 9'h004, 1'b1, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_conditions;
    set_pc(9'h010); load_st(3'b001);
    do_branch(3'b001, 1'b0, 1'b0, 8'h05, 16'h0000, 9'h010, 9'h016, 1'b1, 1'b0, 3'b000, 1'b0);
    set_pc(9'h010);
    do_branch(3'b010, 1'b0, 1'b0, 8'h05, 16'h0000, 9'h010, 9'h011, 1'b0, 1'b0, 3'b000, 1'b0);
    do_branch(3'b100, 1'b0, 1'b0, 8'hF0, 16'h0000, 9'h011, 9'h002, 1'b1, 1'b0, 3'b000, 1'b0);
    do_branch(3'b101, 1'b0, 1'b0, 8'h07, 16'h0000, 9'h002, 9'h003, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_wrap;
    set_pc(9'h000); load_st(3'b010);
    do_branch(3'b011, 1'b0, 1'b0, 8'hFE, 16'h0000, 9'h000, 9'h1FF, 1'b1, 1'b0, 3'b000, 1'b0);
    set_pc(9'h000); load_st(3'b110);
    do_branch(3'b011, 1'b0, 1'b0, 8'hFE, 16'h0000, 9'h000, 9'h001, 1'b0, 1'b0, 3'b000, 1'b0);
    do_branch(3'b100, 1'b0, 1'b0, 8'h7F, 16'h0000, 9'h001, 9'h002, 1'b0, 1'b0, 3'b000, 1'b0);
    set_pc(9'h1F0);
    do_branch(3'b000, 1'b0, 1'b0, 8'h7F, 16'h0000, 9'h1F0, 9'h070, 1'b1, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_indirect_link;
    set_pc(9'h040);
    do_branch(3'b000, 1'b1, 1'b1, 8'h00, 16'hABCD, 9'h040, 9'h1CD, 1'b1, 1'b0, 3'b000, 1'b0);
    do_branch(3'b111, 1'b1, 1'b1, 8'h00, 16'h1234, 9'h1CD, 9'h1CE, 1'b0, 1'b0, 3'b000, 1'b0);
    do_branch(3'b000, 1'b0, 1'b1, 8'h10, 16'h0000, 9'h1CE, 9'h1DF, 1'b1, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_status_same_cycle;
    load_st(3'b000); set_pc(9'h050);
    do_branch(3'b001, 1'b0, 1'b0, 8'h05, 16'h0000, 9'h050, 9'h051, 1'b0, 1'b1, 3'b001, 1'b1);
    vectors++; if (status !== 3'b001) begin miscompares++; $display("FAIL status_after: %b expected 001", status); end
  endtask

  task automatic test_pc_load_abort;
    set_pc(9'h060);
    @(negedge clk); br_req = 1'b1; br_cond = 3'b000; br_indirect = 1'b0; br_link = 1'b1; imm = 8'h10;
    @(posedge clk); @(negedge clk); br_req = 1'b0;
    @(negedge clk); pc_load = 1'b1; pc_init = 9'h100;
    @(posedge clk); @(negedge clk); pc_load = 1'b0;
    vectors++; if (pc !== 9'h100) begin miscompares++; $display("FAIL abort_pc: pc=%h expected 100", pc); end
    vectors++; if ({br_done, link_we, br_busy} !== 3'b000) begin miscompares++; $display("FAIL abort_flags: done,lwe,busy=%b expected 000", {br_done, link_we, br_busy}); end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      vectors++; if (br_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: br_done=%b expected 0", br_done); end
    end
    vectors++; if (link_val !== model_link) begin miscompares++; $display("FAIL abort_link_val: %h expected %h", link_val, model_link); end
    set_pc(9'h1FF);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk); pc_inc = 1'b1;
      @(posedge clk); @(negedge clk); pc_inc = 1'b0;
      vectors++; if (pc !== 9'(n)) begin miscompares++; $display("FAIL pc_inc: pc=%h expected %h", pc, 9'(n)); end
    end
    do_branch(3'b000, 1'b0, 1'b0, 8'h02, 16'h0000, 9'h001, 9'h004, 1'b1, 1'b0, 3'b000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_eval();
    test_conditions();
    test_wrap();
    test_indirect_link();
    test_status_same_cycle();
    test_pc_load_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
